// File: rtl/blowfish_core.sv
// Blowfish block cipher datapath: one 64-bit block per transaction, ROUNDS Feistel rounds plus output whitening.
// Latency 7*ROUNDS+3 cycles from input handshake to out_valid; single transaction in flight, in_ready only in IDLE.
module blowfish_core #(
  parameter int ROUNDS = 16,
  parameter int P_AW   = $clog2(ROUNDS + 2)
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            decrypt,
  input  logic [31:0]     xl_in,
  input  logic [31:0]     xr_in,
  output logic [9:0]      S_addr,
  input  logic [31:0]     S_data,
  output logic [P_AW-1:0] P_addr,
  input  logic [31:0]     P_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     xl_out,
  output logic [31:0]     xr_out
);

  typedef enum logic [3:0] {
    IDLE, RP, RX, RS0, RS1, RS2, RS3, RF, FA, FB, FC, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       xl_q, xl_d, xr_q, xr_d, acc_q, acc_d;
  logic [31:0]       xl_out_q, xl_out_d, xr_out_q, xr_out_d;
  logic [P_AW-1:0]   rnd_q, rnd_d;
  logic              dec_q, dec_d;

  // Decrypt walks the P-array backwards.
  function automatic logic [P_AW-1:0] pidx(input logic dec, input logic [P_AW-1:0] k);
    return dec ? (P_AW'(ROUNDS + 1) - k) : k;
  endfunction

  always_comb begin
    state_d   = state_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    acc_d     = acc_q;
    xl_out_d  = xl_out_q;
    xr_out_d  = xr_out_q;
    rnd_d     = rnd_q;
    dec_d     = dec_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    S_addr    = '0;
    P_addr    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xl_d    = xl_in;
          xr_d    = xr_in;
          dec_d   = decrypt;
          rnd_d   = '0;
          state_d = RP;
        end
      end
      RP: begin
        P_addr  = pidx(dec_q, rnd_q);
        state_d = RX;
      end
      RX: begin
        xl_d    = xl_q ^ P_data;
        state_d = RS0;
      end
      RS0: begin
        S_addr  = {2'd0, xl_q[31:24]};
        state_d = RS1;
      end
      RS1: begin
        S_addr  = {2'd1, xl_q[23:16]};
        acc_d   = S_data;
        state_d = RS2;
      end
      RS2: begin
        S_addr  = {2'd2, xl_q[15:8]};
        acc_d   = acc_q + S_data;
        state_d = RS3;
      end
      RS3: begin
        S_addr  = {2'd3, xl_q[7:0]};
        acc_d   = acc_q ^ S_data;
        state_d = RF;
      end
      RF: begin
        xl_d    = xr_q ^ (acc_q + S_data);
        xr_d    = xl_q;
        rnd_d   = rnd_q + P_AW'(1);
        state_d = ((rnd_q + P_AW'(1)) < P_AW'(ROUNDS)) ? RP : FA;
      end
      FA: begin
        P_addr  = pidx(dec_q, P_AW'(ROUNDS));
        state_d = FB;
      end
      // Final whitening also undoes the swap of the last round.
      FB: begin
        P_addr   = pidx(dec_q, P_AW'(ROUNDS + 1));
        xr_out_d = xl_q ^ P_data;
        state_d  = FC;
      end
      FC: begin
        xl_out_d = xr_q ^ P_data;
        state_d  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= IDLE;
      xl_q     <= '0;
      xr_q     <= '0;
      acc_q    <= '0;
      xl_out_q <= '0;
      xr_out_q <= '0;
      rnd_q    <= '0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xl_q     <= xl_d;
      xr_q     <= xr_d;
      acc_q    <= acc_d;
      xl_out_q <= xl_out_d;
      xr_out_q <= xr_out_d;
      rnd_q    <= rnd_d;
      dec_q    <= dec_d;
    end
  end

  assign xl_out = xl_out_q;
  assign xr_out = xr_out_q;

endmodule

// File: tb/tb_blowfish_core.sv
// Directed bench for blowfish_core: small hand-worked boxes, handshake/reset corners, and the zero-key vector.
// Standard boxes are rebuilt from the hex digits of pi, then key-expanded for the all-zero key.
module tb_blowfish_core;
  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] xl_in = '0;
  logic [31:0] xr_in = '0;
  logic [31:0] S_data, P_data;
  logic        in_ready, out_valid;
  logic [9:0]  S_addr;
  logic [4:0]  P_addr;
  logic [31:0] xl_out, xr_out;

  int total = 0;
  int bad = 0;

  logic [31:0] smem [0:1023];
  logic [31:0] pmem [0:31];
  logic [4:0]  tr_p [0:127];
  logic [9:0]  tr_s [0:127];

  localparam int NW = 1048;
  bit [31:0] pi_w [NW];
  bit [31:0] term [NW];
  bit [31:0] tmp  [NW];

  blowfish_core #(.ROUNDS(16)) dut (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready),
    .decrypt(decrypt), .xl_in(xl_in), .xr_in(xr_in), .S_addr(S_addr), .S_data(S_data),
    .P_addr(P_addr), .P_data(P_data), .out_valid(out_valid), .out_ready(out_ready),
    .xl_out(xl_out), .xr_out(xr_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    S_data <= smem[S_addr];
    P_data <= pmem[P_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) smem[i] = '0;
    for (int i = 0; i < 32; i++) pmem[i] = '0;
  endtask

  // Handshake a block, then wait (bounded) for out_valid while logging addresses.
  task automatic run_txn(input logic dec, input logic [31:0] l, input logic [31:0] r,
                         output logic [31:0] ol, output logic [31:0] orr, output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; decrypt = dec; xl_in = l; xr_in = r;
    @(posedge clk); #1;
    in_valid = 1'b0; decrypt = ~dec; xl_in = ~l;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      if (lat < 128) begin
        tr_p[lat] = P_addr;
        tr_s[lat] = S_addr;
      end
      @(posedge clk); #1;
      lat++;
    end
    ol = xl_out;
    orr = xr_out;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Big fixed-point pi: word 0 is the integer part, then fraction words.
  task automatic div_term(input bit to_tmp, input longint unsigned d, output bit nz);
    longint unsigned rem, q;
    rem = 0; nz = 1'b0;
    for (int i = 0; i < NW; i++) begin
      rem = (rem << 32) | {32'd0, term[i]};
      q = rem / d;
      rem = rem - q * d;
      if (to_tmp) tmp[i] = q[31:0];
      else term[i] = q[31:0];
      if (q != 0) nz = 1'b1;
    end
  endtask

  task automatic acc_tmp(input bit sub);
    longint c;
    c = 0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (sub) c = longint'({32'd0, pi_w[i]}) - longint'({32'd0, tmp[i]}) + c;
      else     c = longint'({32'd0, pi_w[i]}) + longint'({32'd0, tmp[i]}) + c;
      pi_w[i] = c[31:0];
      c = c >>> 32;
    end
  endtask

  task automatic add_atan(input int x, input int mult, input bit sub);
    bit nz, dummy;
    for (int i = 0; i < NW; i++) term[i] = '0;
    term[0] = 32'(mult);
    div_term(1'b0, longint'(x), nz);
    for (int i = 0; i < NW; i++) tmp[i] = term[i];
    acc_tmp(sub);
    for (int k = 1; nz; k++) begin
      div_term(1'b0, longint'(x * x), nz);
      div_term(1'b1, longint'(2 * k + 1), dummy);
      acc_tmp(sub ^ k[0]);
    end
  endtask

  function automatic logic [31:0] bf_f(input logic [31:0] x);
    return ((smem[{2'b00, x[31:24]}] + smem[{2'b01, x[23:16]}]) ^ smem[{2'b10, x[15:8]}])
           + smem[{2'b11, x[7:0]}];
  endfunction

  task automatic bf_enc(inout logic [31:0] l, inout logic [31:0] r);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      l = l ^ pmem[i];
      r = r ^ bf_f(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ pmem[16];
    l = l ^ pmem[17];
  endtask

  task automatic zero_key_schedule();
    logic [31:0] l, r;
    for (int i = 0; i < NW; i++) pi_w[i] = '0;
    add_atan(5, 16, 1'b0);
    add_atan(239, 4, 1'b1);
    clear_mem();
    for (int i = 0; i < 18; i++) pmem[i] = pi_w[1 + i];
    for (int i = 0; i < 1024; i++) smem[i] = pi_w[19 + i];
    l = '0; r = '0;
    for (int i = 0; i < 9; i++) begin
      bf_enc(l, r);
      pmem[2 * i] = l;
      pmem[2 * i + 1] = r;
    end
    for (int k = 0; k < 1024; k += 2) begin
      bf_enc(l, r);
      smem[k] = l;
      smem[k + 1] = r;
    end
  endtask

  logic [31:0] ol, orr, hl, hr;
  int lat;

  initial begin
    clear_mem();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_xl_out", xl_out, 32'h0);
    check("rst_xr_out", xr_out, 32'h0);
    check("rst_S_addr", 32'(S_addr), 32'h0);
    check("rst_P_addr", 32'(P_addr), 32'h0);
    @(negedge clk);
    reset_l = 1'b1;

    // Zero boxes: rounds only swap, whitening is identity.
    run_txn(1'b0, 32'h01234567, 32'h89ABCDEF, ol, orr, lat);
    check("t1_latency", 32'(lat), 32'd115);
    check("t1_xl", ol, 32'h89ABCDEF);
    check("t1_xr", orr, 32'h01234567);
    check("t1_rp_paddr", 32'(tr_p[0]), 32'd0);
    check("t1_rs0", 32'(tr_s[2]), 32'h001);
    check("t1_rs1", 32'(tr_s[3]), 32'h123);
    check("t1_rs2", 32'(tr_s[4]), 32'h245);
    check("t1_rs3", 32'(tr_s[5]), 32'h367);
    check("t1_rp1_paddr", 32'(tr_p[7]), 32'd1);
    ack();

    pmem[0] = 32'h11111111;
    run_txn(1'b0, 32'h01234567, 32'h89ABCDEF, ol, orr, lat);
    check("t2e_xl", ol, 32'h89ABCDEF);
    check("t2e_xr", orr, 32'h10325476);
    ack();
    run_txn(1'b1, 32'h01234567, 32'h89ABCDEF, ol, orr, lat);
    check("t2d_xl", ol, 32'h98BADCFE);
    check("t2d_xr", orr, 32'h01234567);
    check("t2d_rp_paddr", 32'(tr_p[0]), 32'd17);
    check("t2d_rp1_paddr", 32'(tr_p[7]), 32'd16);
    ack();

    // Consumer stall: result held, new input refused.
    run_txn(1'b0, 32'h01234567, 32'h89ABCDEF, hl, hr, lat);
    check("hold_first_xr", hr, 32'h10325476);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      xl_in = $urandom;
      xr_in = $urandom;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_xl", xl_out, 32'h89ABCDEF);
      check("hold_xr", xr_out, 32'h10325476);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of round 5.
    clear_mem();
    @(negedge clk);
    in_valid = 1'b1; decrypt = 1'b0; xl_in = 32'h01234567; xr_in = 32'h89ABCDEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    check("r5_rs0_S_addr", 32'(S_addr), 32'h089);
    reset_l = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_S_addr", 32'(S_addr), 32'h0);
    check("midrst_xl_out", xl_out, 32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    run_txn(1'b0, 32'h01234567, 32'h89ABCDEF, ol, orr, lat);
    check("postrst_latency", 32'(lat), 32'd115);
    check("postrst_xl", ol, 32'h89ABCDEF);
    check("postrst_xr", orr, 32'h01234567);
    ack();

    // Published vector for the all-zero key.
    zero_key_schedule();
    run_txn(1'b0, 32'h0, 32'h0, ol, orr, lat);
    check("zk_enc_latency", 32'(lat), 32'd115);
    check("zk_enc_xl", ol, 32'h4EF99745);
    check("zk_enc_xr", orr, 32'h6198DD78);
    check("zk_rp_paddr", 32'(tr_p[0]), 32'd0);
    for (int b = 0; b < 4; b++) check("zk_box_sel", 32'(tr_s[2 + b][9:8]), 32'(b));
    ack();
    run_txn(1'b1, 32'h4EF99745, 32'h6198DD78, ol, orr, lat);
    check("zk_dec_xl", ol, 32'h0);
    check("zk_dec_xr", orr, 32'h0);
    check("zk_dec_rp_paddr", 32'(tr_p[0]), 32'd17);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
